// File: rtl/dragster_line_capture.sv
// dragster_line_capture: frames the Dragster sensor pixel stream into fixed-length
// lines. Pixels are buffered in a small FIFO and presented on a valid/ready stream
// with first/last markers.
// Ports:
//   clk, reset_n               clock, synchronous active-low reset
//   enable                     capture permitted (sensor configured)
//   line_start                 one-cycle line start strobe from the sensor interface
//   pix_data, pix_valid        sensor pixel input
//   m_data, m_valid, m_ready   output pixel stream (valid/ready)
//   m_first, m_last            output pixel is index 0 / LINE_LENGTH-1 of its line
//   line_count                 completed lines written to the FIFO (wraps)
//   overflow, line_error       sticky error flags, cleared only by reset
module dragster_line_capture #(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned LINE_LENGTH = 1024,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   line_start,
  input  logic [PIXEL_WIDTH-1:0] pix_data,
  input  logic                   pix_valid,
  output logic [PIXEL_WIDTH-1:0] m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_first,
  output logic                   m_last,
  output logic [15:0]            line_count,
  output logic                   overflow,
  output logic                   line_error
);

  localparam int unsigned IDX_W   = 16;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = PIXEL_WIDTH + 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_LENGTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_LINE, CAPTURE, DROP} state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n, cur_idx;
  logic             push, push_first, push_last;
  logic             line_done, set_ovf, set_err;

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr, rd_ptr_n;
  logic [CNT_W-1:0]   count, avail;
  logic               fifo_full, pop;

  // Capture control: line framing, error detection, FIFO write request
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    cur_idx    = idx;
    push       = 1'b0;
    push_first = 1'b0;
    push_last  = 1'b0;
    line_done  = 1'b0;
    set_ovf    = 1'b0;
    set_err    = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      idx_n   = '0;
    end else begin
      case (state)
        IDLE: state_n = WAIT_LINE;
        WAIT_LINE: begin
          if (line_start) begin
            state_n = CAPTURE;
            idx_n   = '0;
          end
        end
        CAPTURE: begin
          // A restart takes effect this cycle: a coincident pixel is pixel 0
          if (line_start) begin
            set_err = (idx != '0);
            cur_idx = '0;
          end
          idx_n = cur_idx;
          if (pix_valid) begin
            if (fifo_full) begin
              set_ovf = 1'b1;
              state_n = DROP;
            end else begin
              push       = 1'b1;
              push_first = (cur_idx == '0);
              push_last  = (cur_idx == LAST_IDX);
              if (cur_idx == LAST_IDX) begin
                line_done = 1'b1;
                state_n   = WAIT_LINE;
                idx_n     = '0;
              end else begin
                idx_n = cur_idx + 16'd1;
              end
            end
          end
        end
        DROP: begin
          if (line_start) begin
            state_n = CAPTURE;
            idx_n   = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Control state, line counter and sticky flags
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      idx        <= '0;
      line_count <= '0;
      overflow   <= 1'b0;
      line_error <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (line_done) line_count <= line_count + 16'd1;
      if (set_ovf)   overflow   <= 1'b1;
      if (set_err)   line_error <= 1'b1;
    end
  end

  // Occupancy includes the entry shown on m_*; it leaves only on a transfer
  assign fifo_full = (count == FULL_CNT);
  assign pop       = m_valid & m_ready;
  assign rd_ptr_n  = rd_ptr + PTR_W'(pop);
  assign avail     = count - CNT_W'(pop);

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {push_first, push_last, pix_data};
  end

  // FIFO pointers and registered output view of the head entry.
  // Only entries stored before this edge are shown, so a pixel written on
  // edge N appears after edge N+1 and there is no pix_* to m_* path.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_first <= 1'b0;
      m_last  <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr + PTR_W'(push);
      rd_ptr  <= rd_ptr_n;
      count   <= count + CNT_W'(push) - CNT_W'(pop);
      m_valid <= (avail != '0);
      if (avail != '0) {m_first, m_last, m_data} <= mem[rd_ptr_n];
    end
  end

endmodule
